// File: rtl/sparc_alu_seq_if.sv
// sparc_alu_seq_if: handshake and result bus of the registered SPARC ALU.
//   master (execute stage / producer-consumer side):
//     drives in_valid, op, a, b, out_ready
//     samples in_ready, out_valid, result, illegal, icc, y_out
//   slave (sparc_alu_seq): the mirror image of master.
interface sparc_alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             illegal;
    logic [3:0]       icc;
    logic [WIDTH-1:0] y_out;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, illegal, icc, y_out
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, illegal, icc, y_out
    );
endinterface

// File: rtl/sparc_alu_seq.sv
// sparc_alu_seq: registered SPARC integer ALU with internal icc.
//
// Executes SPARC op3 arithmetic, logical and shift codes on WIDTH-bit
// operands behind a valid/ready handshake. Single-cycle ops load result,
// illegal and icc on the accepting edge. ADDX/SUBX use the registered
// icc.C, so carry chains need no bubble.
//
// Optional feature macro: SPARC_ALU_MUL_EN
//   defined   : UMUL/SMUL run as a WIDTH-cycle radix-2 shift-add multiply,
//               low half to result, high half to y_out.
//   undefined : UMUL/SMUL are unsupported ops, y_out is tied to 0.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : sparc_alu_seq_if.slave
//          in_valid/in_ready/op/a/b      operation input handshake
//          out_valid/out_ready/result    result handshake
//          illegal                       result is from an unsupported op
//          icc {N,Z,V,C}                 architectural condition codes
//          y_out                         high half of last multiply
//
// MUL FSM (only with SPARC_ALU_MUL_EN):
//   state  | meaning
//   S_IDLE | accepting ops; single-cycle ops complete here
//   S_MUL  | iterative multiply in progress, in_ready held low
module sparc_alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SH_W  = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst,
    sparc_alu_seq_if.slave bus
);

    localparam int M = WIDTH - 1;

    localparam logic [5:0] OP_ADD    = 6'b000000;
    localparam logic [5:0] OP_AND    = 6'b000001;
    localparam logic [5:0] OP_OR     = 6'b000010;
    localparam logic [5:0] OP_XOR    = 6'b000011;
    localparam logic [5:0] OP_SUB    = 6'b000100;
    localparam logic [5:0] OP_ANDN   = 6'b000101;
    localparam logic [5:0] OP_ORN    = 6'b000110;
    localparam logic [5:0] OP_XNOR   = 6'b000111;
    localparam logic [5:0] OP_ADDX   = 6'b001000;
    localparam logic [5:0] OP_SUBX   = 6'b001100;
    localparam logic [5:0] OP_ADDCC  = 6'b010000;
    localparam logic [5:0] OP_ANDCC  = 6'b010001;
    localparam logic [5:0] OP_ORCC   = 6'b010010;
    localparam logic [5:0] OP_XORCC  = 6'b010011;
    localparam logic [5:0] OP_SUBCC  = 6'b010100;
    localparam logic [5:0] OP_ANDNCC = 6'b010101;
    localparam logic [5:0] OP_ORNCC  = 6'b010110;
    localparam logic [5:0] OP_XNORCC = 6'b010111;
    localparam logic [5:0] OP_ADDXCC = 6'b011000;
    localparam logic [5:0] OP_SUBXCC = 6'b011100;
    localparam logic [5:0] OP_SLL    = 6'b100101;
    localparam logic [5:0] OP_SRL    = 6'b100110;
    localparam logic [5:0] OP_SRA    = 6'b100111;
`ifdef SPARC_ALU_MUL_EN
    localparam logic [5:0] OP_UMUL   = 6'b001010;
    localparam logic [5:0] OP_SMUL   = 6'b001011;
`endif

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             illegal_q;
    logic [3:0]       icc_q;

    logic             in_ready_i;
    logic             accept;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             cc_we;
    logic             flag_v;
    logic             flag_c;
    logic [3:0]       icc_new;
    logic             mul_start;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic             cin;
    logic [SH_W-1:0]  shamt;

    assign accept = bus.in_valid & in_ready_i;
    // op3 bit 3 marks the X (carry-consuming) add/sub variants.
    assign cin    = bus.op[3] & icc_q[0];
    assign shamt  = bus.b[SH_W-1:0];

    always_comb begin
        alu_res   = '0;
        alu_ill   = 1'b0;
        cc_we     = 1'b0;
        flag_v    = 1'b0;
        flag_c    = 1'b0;
        mul_start = 1'b0;
        add_w     = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
        sub_w     = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, cin};
        case (bus.op)
            OP_ADD, OP_ADDX, OP_ADDCC, OP_ADDXCC: begin
                alu_res = add_w[WIDTH-1:0];
                flag_c  = add_w[WIDTH];
                flag_v  = (bus.a[M] == bus.b[M]) & (add_w[M] != bus.a[M]);
                cc_we   = bus.op[4];
            end
            OP_SUB, OP_SUBX, OP_SUBCC, OP_SUBXCC: begin
                alu_res = sub_w[WIDTH-1:0];
                flag_c  = sub_w[WIDTH];
                flag_v  = (bus.a[M] != bus.b[M]) & (sub_w[M] != bus.a[M]);
                cc_we   = bus.op[4];
            end
            OP_AND, OP_ANDCC: begin
                alu_res = bus.a & bus.b;
                cc_we   = bus.op[4];
            end
            OP_ANDN, OP_ANDNCC: begin
                alu_res = bus.a & ~bus.b;
                cc_we   = bus.op[4];
            end
            OP_OR, OP_ORCC: begin
                alu_res = bus.a | bus.b;
                cc_we   = bus.op[4];
            end
            OP_ORN, OP_ORNCC: begin
                alu_res = bus.a | ~bus.b;
                cc_we   = bus.op[4];
            end
            OP_XOR, OP_XORCC: begin
                alu_res = bus.a ^ bus.b;
                cc_we   = bus.op[4];
            end
            OP_XNOR, OP_XNORCC: begin
                alu_res = bus.a ^ ~bus.b;
                cc_we   = bus.op[4];
            end
            OP_SLL: alu_res = bus.a << shamt;
            OP_SRL: alu_res = bus.a >> shamt;
            OP_SRA: alu_res = $unsigned($signed(bus.a) >>> shamt);
`ifdef SPARC_ALU_MUL_EN
            OP_UMUL, OP_SMUL: mul_start = 1'b1;
`endif
            default: alu_ill = 1'b1;
        endcase
        icc_new = {alu_res[M], (alu_res == '0), flag_v, flag_c};
    end

`ifdef SPARC_ALU_MUL_EN
    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               mul_done;
    logic [SH_W-1:0]    cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   hi_q;
    logic               neg_q;
    logic [WIDTH-1:0]   y_q;
    logic [WIDTH:0]     pp;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] full;
    logic [2*WIDTH-1:0] prod;
    logic               mul_sgn;

    assign mul_sgn = bus.op[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        in_ready_i = 1'b0;
        mul_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_i = !out_valid_q | bus.out_ready;
                if (bus.in_valid & in_ready_i & mul_start) state_d = S_MUL;
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    mul_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One shift-add step: {hi, mplier} shifts right by one each cycle, so
    // after WIDTH steps it holds the full unsigned product.
    always_comb begin
        pp      = {1'b0, hi_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        step_hi = pp[WIDTH:1];
        step_lo = {pp[0], mplier_q[WIDTH-1:1]};
        full    = {step_hi, step_lo};
        prod    = neg_q ? -full : full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            neg_q    <= 1'b0;
            y_q      <= '0;
        end else if (accept & mul_start) begin
            // SMUL multiplies magnitudes and fixes the sign at the end.
            cnt_q    <= SH_W'(WIDTH - 1);
            mcand_q  <= (mul_sgn & bus.a[M]) ? -bus.a : bus.a;
            mplier_q <= (mul_sgn & bus.b[M]) ? -bus.b : bus.b;
            hi_q     <= '0;
            neg_q    <= mul_sgn & (bus.a[M] ^ bus.b[M]);
        end else if (state_q == S_MUL) begin
            cnt_q    <= cnt_q - 1'b1;
            hi_q     <= step_hi;
            mplier_q <= step_lo;
            if (mul_done) y_q <= prod[2*WIDTH-1:WIDTH];
        end
    end

    assign bus.y_out = y_q;
`else
    assign in_ready_i = !out_valid_q | bus.out_ready;
    assign bus.y_out  = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
            icc_q       <= 4'b0000;
        end else if (accept & !mul_start) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            illegal_q   <= alu_ill;
            if (cc_we) icc_q <= icc_new;
`ifdef SPARC_ALU_MUL_EN
        end else if (mul_done) begin
            out_valid_q <= 1'b1;
            result_q    <= prod[WIDTH-1:0];
            illegal_q   <= 1'b0;
`endif
        end else if (bus.out_ready) begin
            // Also covers a multiply accept, which consumes any old result.
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_i;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.illegal   = illegal_q;
    assign bus.icc       = icc_q;

endmodule

// File: tb/tb_sparc_alu_seq.sv
module tb_sparc_alu_seq;

    localparam logic [5:0] OP_ADD    = 6'b000000;
    localparam logic [5:0] OP_AND    = 6'b000001;
    localparam logic [5:0] OP_SUB    = 6'b000100;
    localparam logic [5:0] OP_ANDN   = 6'b000101;
    localparam logic [5:0] OP_ORN    = 6'b000110;
    localparam logic [5:0] OP_XNOR   = 6'b000111;
    localparam logic [5:0] OP_ADDX   = 6'b001000;
    localparam logic [5:0] OP_UMUL   = 6'b001010;
    localparam logic [5:0] OP_SMUL   = 6'b001011;
    localparam logic [5:0] OP_SUBX   = 6'b001100;
    localparam logic [5:0] OP_ADDCC  = 6'b010000;
    localparam logic [5:0] OP_ORCC   = 6'b010010;
    localparam logic [5:0] OP_XORCC  = 6'b010011;
    localparam logic [5:0] OP_SUBCC  = 6'b010100;
    localparam logic [5:0] OP_ADDXCC = 6'b011000;
    localparam logic [5:0] OP_UMULCC = 6'b011010;
    localparam logic [5:0] OP_SUBXCC = 6'b011100;
    localparam logic [5:0] OP_SLL    = 6'b100101;
    localparam logic [5:0] OP_SRL    = 6'b100110;
    localparam logic [5:0] OP_SRA    = 6'b100111;
    localparam logic [5:0] OP_BAD    = 6'b111111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sparc_alu_seq_if #(.WIDTH(32)) bus ();
    sparc_alu_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        logic [3:0]  icc;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] res,
                                input logic ill, input logic [3:0] icc);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.ill = ill; v.icc = icc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int n;
        // icc column is {N,Z,V,C}, tracked by hand through the sequence.
        vecs[0]  = mk(OP_ADDCC,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 4'b0101);
        vecs[1]  = mk(OP_ADDX,   32'h00000005, 32'h00000006, 32'h0000000C, 1'b0, 4'b0101);
        vecs[2]  = mk(OP_SUBCC,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 4'b1001);
        vecs[3]  = mk(OP_SUBX,   32'h0000000A, 32'h00000003, 32'h00000006, 1'b0, 4'b1001);
        vecs[4]  = mk(OP_SUBCC,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 4'b0010);
        vecs[5]  = mk(OP_SRA,    32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 4'b0010);
        vecs[6]  = mk(OP_BAD,    32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 4'b0010);
        vecs[7]  = mk(OP_AND,    32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F, 1'b0, 4'b0010);
        vecs[8]  = mk(OP_ANDN,   32'hF0F0FFFF, 32'h0FF0F00F, 32'hF0000FF0, 1'b0, 4'b0010);
        vecs[9]  = mk(OP_ORN,    32'h00000000, 32'hFFFF0000, 32'h0000FFFF, 1'b0, 4'b0010);
        vecs[10] = mk(OP_XNOR,   32'h12345678, 32'h12345678, 32'hFFFFFFFF, 1'b0, 4'b0010);
        vecs[11] = mk(OP_XORCC,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 1'b0, 4'b0100);
        vecs[12] = mk(OP_ORCC,   32'h80000000, 32'h00000001, 32'h80000001, 1'b0, 4'b1000);
        vecs[13] = mk(OP_SLL,    32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0, 4'b1000);
        vecs[14] = mk(OP_SRL,    32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 4'b1000);
        vecs[15] = mk(OP_ADDCC,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 4'b1010);
        vecs[16] = mk(OP_ADDXCC, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 4'b1000);
        vecs[17] = mk(OP_UMULCC, 32'h00000002, 32'h00000003, 32'h00000000, 1'b1, 4'b1000);
        vecs[18] = mk(OP_SUB,    32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 4'b1000);
        vecs[19] = mk(OP_SUBXCC, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 4'b0100);
        vecs[20] = mk(OP_ADDX,   32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 4'b0100);

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result",    bus.result,         32'd0);
        check("reset illegal",   32'(bus.illegal),   32'd0);
        check("reset icc",       32'(bus.icc),       32'd0);
        check("reset y_out",     bus.y_out,          32'd0);
        check("reset in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Table ops go back-to-back, one per cycle, with out_ready high.
        for (int i = 0; i < NV; i++) begin
            bus.op = vecs[i].op; bus.a = vecs[i].a; bus.b = vecs[i].b;
            bus.in_valid = 1'b1;
            check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("vec%0d result", i),    bus.result,         vecs[i].res);
            check($sformatf("vec%0d illegal", i),   32'(bus.illegal),   32'(vecs[i].ill));
            check($sformatf("vec%0d icc", i),       32'(bus.icc),       32'(vecs[i].icc));
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("drain out_valid", 32'(bus.out_valid), 32'd0);

`ifndef SPARC_ALU_MUL_EN
        run_op(OP_UMUL, 32'hFFFFFFFF, 32'h2);
        check("umul_off illegal", 32'(bus.illegal), 32'd1);
        check("umul_off result",  bus.result,       32'd0);
        check("umul_off y_out",   bus.y_out,        32'd0);
        @(posedge clk); #1;
`endif

        // Backpressure: result holds and in_ready stays low while stalled.
        bus.out_ready = 1'b0;
        run_op(OP_ADD, 32'd1, 32'd2);
        check("bp first result", bus.result, 32'd3);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d out_valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp%0d result", k),    bus.result,         32'd3);
            check($sformatf("bp%0d in_ready", k),  32'(bus.in_ready),  32'd0);
        end
        bus.op = OP_ADD; bus.a = 32'd10; bus.b = 32'd20; bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp release result",    bus.result,         32'd30);
        check("bp release out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        check("bp consumed out_valid", 32'(bus.out_valid), 32'd0);

`ifdef SPARC_ALU_MUL_EN
        run_op(OP_UMUL, 32'hFFFFFFFF, 32'h2);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            check($sformatf("umul busy%0d in_ready", n), 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check("umul busy cycles", 32'(n), 32'd32);
        check("umul result", bus.result, 32'hFFFFFFFE);
        check("umul y_out",  bus.y_out,  32'h00000001);
        check("umul icc",    32'(bus.icc), 32'b0100);
        @(posedge clk); #1;

        run_op(OP_SMUL, 32'hFFFFFFFD, 32'h4);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("smul busy cycles", 32'(n), 32'd32);
        check("smul result", bus.result, 32'hFFFFFFF4);
        check("smul y_out",  bus.y_out,  32'hFFFFFFFF);
        check("smul illegal", 32'(bus.illegal), 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a multiply.
        run_op(OP_UMUL, 32'd7, 32'd9);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mul out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mul y_out",     bus.y_out,          32'd0);
        check("rst_mul icc",       32'(bus.icc),       32'd0);
        check("rst_mul in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_op(OP_ADD, 32'd100, 32'd23);
        check("post_rst_mul result",    bus.result,         32'd123);
        check("post_rst_mul out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
`endif

        // Reset in the middle of a stall.
        bus.out_ready = 1'b0;
        run_op(OP_SUBCC, 32'd3, 32'd5);
        check("stall icc", 32'(bus.icc), 32'b1001);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_stall out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_stall result",    bus.result,         32'd0);
        check("rst_stall illegal",   32'(bus.illegal),   32'd0);
        check("rst_stall icc",       32'(bus.icc),       32'd0);
        check("rst_stall y_out",     bus.y_out,          32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        run_op(OP_ADD, 32'd7, 32'd8);
        check("post_rst result",    bus.result,         32'd15);
        check("post_rst out_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst illegal",   32'(bus.illegal),   32'd0);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sparc_alu_seq.md
Name: sparc_alu_seq

Overview:
Parametrised, registered successor to the combinational SPARC integer ALU. It executes SPARC arithmetic, logical and shift op3 codes on WIDTH-bit operands behind a valid/ready handshake. It owns the integer condition codes (icc) internally, so ADDX/SUBX chains use the registered carry rather than an external carry input. Sits between the register-file read stage and writeback; the execute stage stalls on in_ready.

Parameters:
WIDTH, 32, operand/result width; power of 2, 8..64.
SH_W, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operation offered
in_ready  out  1  operation accepted when in_valid & in_ready
op  in  6  SPARC op3 code (ADD..XNORCC, SLL/SRL/SRA encodings)
a  in  WIDTH  rs1 value
b  in  WIDTH  rs2 or sign-extended simm13
out_valid  out  1  result register holds an unconsumed result
out_ready  in  1  consumer takes result when out_valid & out_ready
result  out  WIDTH  registered result
illegal  out  1  registered; result belongs to an unsupported op
icc  out  4  {N,Z,V,C}, registered, architectural state
y_out  out  WIDTH  high half of last multiply (0 when feature is off)

Behaviour:
- Reset (async, any state): out_valid=0, result=0, illegal=0, icc=4'b0000, y_out=0, FSM=IDLE. Any in-flight multiply is discarded.
- FSM states:
  - IDLE: single-cycle ops.
  - MUL: iterative multiply; present only with the optional feature.
- in_ready = (state==IDLE) & (!out_valid | out_ready). Back-to-back throughput is one op per cycle.
- Single-cycle op accepted at edge k: result, illegal and icc load at edge k. out_valid is high from k until the consuming edge. Latency 1.
- result, illegal and icc hold stable while out_valid & !out_ready.
- Arithmetic is computed at WIDTH+1 bits:
  - ADD: a+b.
  - ADDX: a+b+icc.C.
  - SUB: a-b.
  - SUBX: a-b-icc.C.
- icc updates only for *CC ops:
  - N = result MSB; Z = (result==0).
  - Add: C = bit WIDTH carry-out; V = (a.msb==b.msb) & (res.msb!=a.msb).
  - Sub: C = borrow (bit WIDTH of the WIDTH+1 subtraction); V = (a.msb!=b.msb) & (res.msb!=a.msb).
  - Logical CC ops: V=0, C=0.
- X ops read icc as it is at the accepting edge. The icc of an immediately preceding CC op is already visible, so chaining needs no bubble.
- Logical ops: AND, ANDN (a&~b), OR, ORN, XOR, XNOR (a^~b).
- Shifts: amount = b[SH_W-1:0]; upper b bits are ignored. SRA replicates a.msb. Shifts never modify icc.
- Unsupported op3: result=0, illegal=1, icc unchanged. The handshake completes normally.

Optional Feature:
Macro SPARC_ALU_MUL_EN.
- Defined:
  - UMUL (001010) and SMUL (001011) are accepted and the FSM enters MUL.
  - Radix-2 shift-add, WIDTH cycles; SMUL negates operands and result around the core.
  - in_ready=0 throughout MUL.
  - On the final cycle: result = low WIDTH bits, y_out = high WIDTH bits, out_valid=1, FSM returns to IDLE. Latency WIDTH+1 edges from accept.
  - icc is unchanged.
- Undefined: those op3 codes are treated as unsupported (illegal=1), there is no MUL state, and y_out is tied to 0.

Test Plan:
- ADDCC a=0xFFFFFFFF b=1, then ADDX a=5 b=6 back-to-back -> result 0 with icc N0 Z1 V0 C1; then result 0xC, icc unchanged.
- SUBCC a=3 b=5 -> 0xFFFFFFFE, icc N1 Z0 V0 C1. SUBCC a=0x80000000 b=1 -> 0x7FFFFFFF, icc N0 Z0 V1 C0.
- SRA a=0x80000000 b=0x24 -> 0xF8000000 (amount 4), icc unchanged. Unsupported op 6'b111111 -> result 0, illegal=1.
- Backpressure: hold out_ready=0 for 3 cycles after an ADD -> result held, in_ready=0. Raise out_ready with a new op present -> consume and accept in the same cycle.
- MUL_EN: UMUL 0xFFFFFFFF*2 -> result 0xFFFFFFFE, y_out 1, in_ready low 32 cycles. SMUL -3*4 -> result 0xFFFFFFF4, y_out 0xFFFFFFFF.
- Assert rst mid-multiply and mid-stall -> all outputs zero immediately. First op accepted after deassert completes normally.
